// File: rtl/magic_mem_responder.sv
// Row-addressed behavioural memory target with a fixed-latency read pipeline
// feeding a bounded in-order response FIFO, flow-controlled by read credits.
module magic_mem_responder #(
    parameter int ROWS    = 256,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int QDEPTH  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [31:0]        i_req_row,
    input  logic [WIDTH-1:0]   i_req_wdata,
    input  logic [WIDTH/8-1:0] i_req_wmask,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [WIDTH-1:0]   o_resp_rdata,
    output logic [31:0]        o_resp_row,
    output logic               o_resp_err
);

    localparam int NBYTES = WIDTH / 8;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] QDEPTH_CNT = CNT_W'(QDEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] rdata;
        logic [31:0]      row;
        logic             err;
    } resp_t;

    logic [WIDTH-1:0]   r_mem [ROWS];
    resp_t              r_pipe [LATENCY];
    logic [LATENCY-1:0] r_pipe_valid;
    resp_t              r_fifo [QDEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_outstanding;

    logic               w_accept;
    logic               w_rd_accept;
    logic               w_wr_accept;
    logic               w_in_range;
    logic [ROW_W-1:0]   w_row_idx;
    logic [WIDTH-1:0]   w_rd_data;
    resp_t              w_rd_entry;
    resp_t              w_head;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit covers reads still in the pipeline, so the FIFO always has room on arrival.
    assign o_req_ready = !i_reset && (r_outstanding < QDEPTH_CNT);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_rd_accept = w_accept && !i_req_we;
    assign w_wr_accept = w_accept && i_req_we;

    assign w_in_range  = (i_req_row < 32'(ROWS));
    assign w_row_idx   = i_req_row[ROW_W-1:0];
    assign w_rd_data   = w_in_range ? r_mem[w_row_idx] : '0;
    assign w_rd_entry  = {w_rd_data, i_req_row, !w_in_range};

    assign w_push       = r_pipe_valid[LATENCY-1];
    assign w_head       = r_fifo[r_rd_ptr];
    assign o_resp_valid = (r_count != '0);
    assign w_pop        = o_resp_valid && i_resp_ready;
    assign o_resp_rdata = o_resp_valid ? w_head.rdata : '0;
    assign o_resp_row   = o_resp_valid ? w_head.row   : '0;
    assign o_resp_err   = o_resp_valid && w_head.err;

    // Memory contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept && w_in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_req_wmask[b]) begin
                    r_mem[w_row_idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid <= LATENCY'({r_pipe_valid, w_rd_accept});
        end
    end

    always_ff @(posedge i_clk) begin
        r_pipe[0] <= w_rd_entry;
        for (int i = 1; i < LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_pipe[LATENCY-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_rd_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && !w_pop && (r_count == QDEPTH_CNT)));

endmodule
